fxu_rs_bank: RTL
================

// Module: fxu_rs_bank
// PURPOSE
//  Reservation-station bank feeding the FXU in the Tomasulo core. Holds dispatched
//  MOV/ADD/JEQ ops and snoops the CDB for pending operands. Issues one ready op per
//  cycle on the FXU request interface (valid, rs_num, op, val0, val1).
//  Frees an entry only when the CDB broadcasts that entry's own rs_num, so tags stay unique.
// PARAMETERS
//  N_RS     4   number of stations (1..16)
//  RS_BASE  0   global tag of entry 0; entry k owns rs_num RS_BASE+k; RS_BASE+N_RS<=64
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-high
//  d_valid     in   1   dispatch request (ignored when d_full=1)
//  d_op        in   4   opcode: 0=MOV 1=ADD 6=JEQ
//  d_rdy0      in   1   operand 0 value present
//  d_val0      in   16  operand 0 value (used if d_rdy0)
//  d_tag0      in   6   producer rs_num for operand 0 (used if !d_rdy0)
//  d_rdy1/d_val1/d_tag1   in 1/16/6   same for operand 1
//  d_full      out  1   no FREE entry this cycle
//  d_rs_num    out  6   tag given to a dispatch accepted this cycle
//  cdb_valid   in   1   CDB broadcast valid
//  cdb_rs_num  in   6   CDB producer tag
//  cdb_data    in   16  CDB result
//  fxu_busy    in   1   FXU cannot accept; suppress issue
//  valid       out  1   issue to FXU
//  rs_num      out  6   issuing entry tag
//  op          out  4   issuing opcode
//  val0, val1  out  16  issuing operands
// BEHAVIOUR
//  Entry state: FREE -> WAIT (an operand missing) -> READY -> ISSUED -> FREE.
//  Reset: all entries FREE, rdy bits 0; valid=0, d_full=0, d_rs_num=RS_BASE.
//   Reset mid-operation drops every entry, including ISSUED ones.
//  Dispatch: when d_valid && !d_full, allocate the lowest-index FREE entry.
//   d_rs_num = RS_BASE+index, combinational, same cycle.
//   Entry is READY next cycle if both operands are ready, else WAIT.
//  CDB snoop: each cycle, every WAIT entry with a pending operand whose tag equals
//   cdb_rs_num (cdb_valid=1) latches cdb_data and sets that rdy bit.
//   Both operands may capture in the same cycle. Entry becomes READY next cycle.
//  Dispatch/CDB bypass: if the dispatched operand tag equals cdb_rs_num in the same
//   cycle, capture cdb_data at allocation.
//  Issue: valid=1 iff some entry is READY and !fxu_busy. Selects the lowest-index READY
//   entry; outputs are combinational from registered state. Chosen entry -> ISSUED
//   at the clock edge. Max one issue per cycle.
//   When valid=0, the other issue outputs are don't-care.
//  Earliest issue is the cycle after dispatch or operand capture.
//  Free: ISSUED entry with cdb_valid && cdb_rs_num==own tag -> FREE next cycle.
//   A freed slot is not allocatable in the same cycle it is freed.
//  Tags outside [RS_BASE, RS_BASE+N_RS) on the CDB only wake operands; they never free entries.
//  d_full = no FREE entry (registered state only).
//  Values pass through unmodified; no arithmetic here.
// TESTING
//  1 Reset, then dispatch MOV rdy0 val0=0x1234 -> d_rs_num=0; next cycle valid=1,
//    rs_num=0, op=0, val0=0x1234.
//  2 Dispatch ADD with op0 rdy=0x0005 and op1 tag=9 pending -> no issue. CDB tag9
//    data=0x0003 -> next cycle issue ADD val0=5, val1=3.
//  3 Dispatch 4 ready ops, fxu_busy=1 -> d_full=1, valid=0. Drop fxu_busy -> issues
//    rs 0,1,2,3 on consecutive cycles. d_full stays 1 until CDB tag 0 arrives, then
//    clears the next cycle.
//  4 Dispatch JEQ with tag0=7 pending while CDB broadcasts tag7 data=0x00AA in the same
//    cycle -> bypass capture; issue next cycle with val0=0x00AA.
//  5 Two entries wait on tag 12 (one on op0, one on op1). CDB tag12 -> both READY;
//    lower index issues first, other issues the following cycle.
//  6 Assert reset with entries WAIT and ISSUED -> next cycle valid=0, d_full=0, and
//    a new dispatch receives rs_num 0.

Source files
------------

// File: rtl/fxu_rs_bank.sv
// Reservation-station bank for the FXU: holds dispatched ops, snoops the CDB for
// missing operands and issues the lowest-index ready entry each cycle.
module fxu_rs_bank #(
    parameter int unsigned N_RS    = 4,
    parameter int unsigned RS_BASE = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        d_valid,
    input  logic [3:0]  d_op,
    input  logic        d_rdy0,
    input  logic [15:0] d_val0,
    input  logic [5:0]  d_tag0,
    input  logic        d_rdy1,
    input  logic [15:0] d_val1,
    input  logic [5:0]  d_tag1,
    output logic        d_full,
    output logic [5:0]  d_rs_num,
    input  logic        cdb_valid,
    input  logic [5:0]  cdb_rs_num,
    input  logic [15:0] cdb_data,
    input  logic        fxu_busy,
    output logic        valid,
    output logic [5:0]  rs_num,
    output logic [3:0]  op,
    output logic [15:0] val0,
    output logic [15:0] val1
);

    localparam int unsigned IdxW = (N_RS > 1) ? $clog2(N_RS) : 1;

    typedef enum logic [1:0] {StFree, StWait, StReady, StIssued} rs_state_e;

    rs_state_e   st_q   [N_RS];
    rs_state_e   st_d   [N_RS];
    logic [3:0]  op_q   [N_RS];
    logic [3:0]  op_d   [N_RS];
    logic        rdy0_q [N_RS];
    logic        rdy0_d [N_RS];
    logic        rdy1_q [N_RS];
    logic        rdy1_d [N_RS];
    logic [15:0] val0_q [N_RS];
    logic [15:0] val0_d [N_RS];
    logic [15:0] val1_q [N_RS];
    logic [15:0] val1_d [N_RS];
    logic [5:0]  tag0_q [N_RS];
    logic [5:0]  tag0_d [N_RS];
    logic [5:0]  tag1_q [N_RS];
    logic [5:0]  tag1_d [N_RS];

    logic            free_found;
    logic            ready_found;
    logic [IdxW-1:0] alloc_idx;
    logic [IdxW-1:0] iss_idx;
    logic            accept;
    logic            d_hit0;
    logic            d_hit1;
    logic            new_rdy0;
    logic            new_rdy1;
    logic [15:0]     new_val0;
    logic [15:0]     new_val1;

    // Priority encoders over registered state only.
    always_comb begin
        free_found  = 1'b0;
        ready_found = 1'b0;
        alloc_idx   = '0;
        iss_idx     = '0;
        for (int unsigned k = 0; k < N_RS; k++) begin
            if (st_q[k] == StFree && !free_found) begin
                free_found = 1'b1;
                alloc_idx  = IdxW'(k);
            end
            if (st_q[k] == StReady && !ready_found) begin
                ready_found = 1'b1;
                iss_idx     = IdxW'(k);
            end
        end
    end

    always_comb begin
        d_full   = !free_found;
        d_rs_num = 6'(RS_BASE) + 6'(alloc_idx);
        accept   = d_valid && free_found;
        valid    = ready_found && !fxu_busy;
        rs_num   = 6'(RS_BASE) + 6'(iss_idx);
        op       = op_q[iss_idx];
        val0     = val0_q[iss_idx];
        val1     = val1_q[iss_idx];
    end

    // A pending operand whose producer is on the CDB this cycle is captured at allocation.
    always_comb begin
        d_hit0   = cdb_valid && (cdb_rs_num == d_tag0);
        d_hit1   = cdb_valid && (cdb_rs_num == d_tag1);
        new_rdy0 = d_rdy0 || d_hit0;
        new_rdy1 = d_rdy1 || d_hit1;
        new_val0 = d_rdy0 ? d_val0 : cdb_data;
        new_val1 = d_rdy1 ? d_val1 : cdb_data;
    end

    always_comb begin
        for (int unsigned k = 0; k < N_RS; k++) begin
            st_d[k]   = st_q[k];
            op_d[k]   = op_q[k];
            rdy0_d[k] = rdy0_q[k];
            rdy1_d[k] = rdy1_q[k];
            val0_d[k] = val0_q[k];
            val1_d[k] = val1_q[k];
            tag0_d[k] = tag0_q[k];
            tag1_d[k] = tag1_q[k];
            unique case (st_q[k])
                StFree: begin
                    if (accept && alloc_idx == IdxW'(k)) begin
                        op_d[k]   = d_op;
                        rdy0_d[k] = new_rdy0;
                        rdy1_d[k] = new_rdy1;
                        val0_d[k] = new_val0;
                        val1_d[k] = new_val1;
                        tag0_d[k] = d_tag0;
                        tag1_d[k] = d_tag1;
                        st_d[k]   = (new_rdy0 && new_rdy1) ? StReady : StWait;
                    end
                end
                StWait: begin
                    if (!rdy0_q[k] && cdb_valid && cdb_rs_num == tag0_q[k]) begin
                        rdy0_d[k] = 1'b1;
                        val0_d[k] = cdb_data;
                    end
                    if (!rdy1_q[k] && cdb_valid && cdb_rs_num == tag1_q[k]) begin
                        rdy1_d[k] = 1'b1;
                        val1_d[k] = cdb_data;
                    end
                    if (rdy0_d[k] && rdy1_d[k]) begin
                        st_d[k] = StReady;
                    end
                end
                StReady: begin
                    if (valid && iss_idx == IdxW'(k)) begin
                        st_d[k] = StIssued;
                    end
                end
                StIssued: begin
                    // Only the entry's own tag frees it, keeping tags unique in flight.
                    if (cdb_valid && cdb_rs_num == 6'(RS_BASE + k)) begin
                        st_d[k] = StFree;
                    end
                end
                default: st_d[k] = StFree;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < N_RS; k++) begin
            if (reset) begin
                st_q[k]   <= StFree;
                rdy0_q[k] <= 1'b0;
                rdy1_q[k] <= 1'b0;
            end else begin
                st_q[k]   <= st_d[k];
                rdy0_q[k] <= rdy0_d[k];
                rdy1_q[k] <= rdy1_d[k];
            end
        end
    end

    // Payload needs no reset: it is only observed once the entry leaves StFree.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < N_RS; k++) begin
            op_q[k]   <= op_d[k];
            val0_q[k] <= val0_d[k];
            val1_q[k] <= val1_d[k];
            tag0_q[k] <= tag0_d[k];
            tag1_q[k] <= tag1_d[k];
        end
    end

endmodule
